// File: rtl/histogram_birimi_p.sv
// Frame histogram with a forwarding read-modify-write pipeline, then ordered bin readout over valid/ready.
// Latency: first bin valid 3 cycles after the last accepted pixel; readout stalls hold address/data. Macro HISTOGRAM_CDF_EN selects cumulative output.
module histogram_birimi_p #(
  parameter int PIXEL_BIT    = 8,
  parameter int SAYAC_BIT    = 17,
  parameter int PIXEL_SAYISI = 76800
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 basla_i,
  input  logic                 pixel_gecerli_i,
  input  logic [PIXEL_BIT-1:0] pixel_i,
  output logic                 pixel_hazir_o,
  output logic                 cikis_gecerli_o,
  input  logic                 cikis_hazir_i,
  output logic [PIXEL_BIT-1:0] cikis_adres_o,
  output logic [SAYAC_BIT-1:0] cikis_veri_o,
  output logic [SAYAC_BIT-1:0] cdf_min_o,
  output logic                 mesgul_o,
  output logic                 bitti_o
);

  localparam int BIN_SAYISI = 1 << PIXEL_BIT;
  localparam int CW = $clog2(PIXEL_SAYISI + 1);
  localparam logic [SAYAC_BIT-1:0] DOYMA   = '1;
  localparam logic [PIXEL_BIT-1:0] SON_ADR = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, READOUT} durum_t;

  durum_t               durum;
  logic [SAYAC_BIT-1:0] bellek [BIN_SAYISI];
  logic [SAYAC_BIT-1:0] ram_q;
  logic [PIXEL_BIT-1:0] okuma_adr, yazma_adr, sil_adr, min_pix;
  logic [SAYAC_BIT-1:0] yazma_veri, kaynak, artmis;
  logic                 yazma_en, kabul, aktar;
  logic [CW-1:0]        pix_say;
  logic                 s1_vld, s2_vld;
  logic [PIXEL_BIT-1:0] s1_adr, s2_adr;
  logic [SAYAC_BIT-1:0] s2_veri;

  always_comb begin
    kabul  = pixel_gecerli_i & pixel_hazir_o;
    aktar  = cikis_gecerli_o & cikis_hazir_i;
    // The RAM read for s1 happened on the same edge as the s2 write, so it missed that update.
    kaynak = (s2_vld && (s2_adr == s1_adr)) ? s2_veri : ram_q;
    artmis = (kaynak == DOYMA) ? kaynak : kaynak + SAYAC_BIT'(1);
    okuma_adr = pixel_i;
    if (durum == READOUT)
      okuma_adr = aktar ? cikis_adres_o + PIXEL_BIT'(1) : cikis_adres_o;
    yazma_en   = (durum == CLEAR) | s1_vld;
    yazma_adr  = (durum == CLEAR) ? sil_adr : s1_adr;
    yazma_veri = (durum == CLEAR) ? '0 : artmis;
  end

  always_ff @(posedge clk_i) begin
    if (yazma_en) bellek[yazma_adr] <= yazma_veri;
    ram_q <= bellek[okuma_adr];
  end

`ifdef HISTOGRAM_CDF_EN
  logic [SAYAC_BIT-1:0] birikim, kumulatif;
  logic [SAYAC_BIT:0]   toplam;
  always_comb begin
    toplam    = {1'b0, birikim} + {1'b0, ram_q};
    kumulatif = toplam[SAYAC_BIT] ? DOYMA : toplam[SAYAC_BIT-1:0];
  end
  assign cikis_veri_o = cikis_gecerli_o ? kumulatif : '0;
`else
  assign cikis_veri_o = cikis_gecerli_o ? ram_q : '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum           <= IDLE;
      pixel_hazir_o   <= 1'b0;
      cikis_gecerli_o <= 1'b0;
      cikis_adres_o   <= '0;
      cdf_min_o       <= '0;
      mesgul_o        <= 1'b0;
      bitti_o         <= 1'b0;
      sil_adr         <= '0;
      min_pix         <= '1;
      pix_say         <= '0;
      s1_vld          <= 1'b0;
      s1_adr          <= '0;
      s2_vld          <= 1'b0;
      s2_adr          <= '0;
      s2_veri         <= '0;
`ifdef HISTOGRAM_CDF_EN
      birikim         <= '0;
`endif
    end else begin
      bitti_o <= 1'b0;
      s1_vld  <= 1'b0;
      s2_vld  <= s1_vld;
      s2_adr  <= s1_adr;
      s2_veri <= artmis;
      case (durum)
        IDLE: begin
          if (basla_i) begin
            durum    <= CLEAR;
            sil_adr  <= '0;
            mesgul_o <= 1'b1;
          end
        end
        CLEAR: begin
          sil_adr   <= sil_adr + PIXEL_BIT'(1);
          min_pix   <= '1;
          cdf_min_o <= '0;
          if (sil_adr == SON_ADR) begin
            durum         <= ACCUM;
            pixel_hazir_o <= 1'b1;
            pix_say       <= '0;
          end
        end
        ACCUM: begin
          s1_vld <= kabul;
          s1_adr <= pixel_i;
          if (kabul) begin
            pix_say <= pix_say + CW'(1);
            if (pixel_i < min_pix) begin
              min_pix   <= pixel_i;
              cdf_min_o <= SAYAC_BIT'(1);
            end else if (pixel_i == min_pix && cdf_min_o != DOYMA) begin
              cdf_min_o <= cdf_min_o + SAYAC_BIT'(1);
            end
            if (pix_say == CW'(PIXEL_SAYISI - 1)) begin
              pixel_hazir_o <= 1'b0;
              durum         <= DRAIN;
            end
          end
        end
        DRAIN: begin
          durum         <= READOUT;
          cikis_adres_o <= '0;
`ifdef HISTOGRAM_CDF_EN
          birikim       <= '0;
`endif
        end
        READOUT: begin
          if (!cikis_gecerli_o) begin
            cikis_gecerli_o <= 1'b1;
          end else if (aktar) begin
`ifdef HISTOGRAM_CDF_EN
            birikim <= kumulatif;
`endif
            if (cikis_adres_o == SON_ADR) begin
              cikis_gecerli_o <= 1'b0;
              bitti_o         <= 1'b1;
              mesgul_o        <= 1'b0;
              durum           <= IDLE;
            end else begin
              cikis_adres_o <= cikis_adres_o + PIXEL_BIT'(1);
            end
          end
        end
        default: durum <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_birimi_p.sv
// Scoreboard bench for histogram_birimi_p: 4-bit pixels, 4-bit counters, 16-pixel frames.
module tb_histogram_birimi_p;

  localparam int PB = 4;
  localparam int SB = 4;
  localparam int N  = 16;
  localparam int NB = 1 << PB;
  localparam int SMAX = (1 << SB) - 1;

  logic          clk = 1'b0;
  logic          rst, basla, pix_vld, cik_rdy;
  logic [PB-1:0] pix;
  logic          pix_rdy, cik_vld, mesgul, bitti;
  logic [PB-1:0] cik_adr;
  logic [SB-1:0] cik_dat, cdf_min;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_pix [N];
  int exp_adr_q [$];
  int exp_dat_q [$];
  int exp_cdf_min;

  histogram_birimi_p #(.PIXEL_BIT(PB), .SAYAC_BIT(SB), .PIXEL_SAYISI(N)) dut (
    .clk_i(clk), .rst_i(rst), .basla_i(basla), .pixel_gecerli_i(pix_vld), .pixel_i(pix),
    .pixel_hazir_o(pix_rdy), .cikis_gecerli_o(cik_vld), .cikis_hazir_i(cik_rdy),
    .cikis_adres_o(cik_adr), .cikis_veri_o(cik_dat), .cdf_min_o(cdf_min),
    .mesgul_o(mesgul), .bitti_o(bitti)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_rdy"}, 32'(pix_rdy), 0);
    chk({tag, "_vld"},     32'(cik_vld), 0);
    chk({tag, "_adr"},     32'(cik_adr), 0);
    chk({tag, "_dat"},     32'(cik_dat), 0);
    chk({tag, "_cdf_min"}, 32'(cdf_min), 0);
    chk({tag, "_mesgul"},  32'(mesgul),  0);
    chk({tag, "_bitti"},   32'(bitti),   0);
  endtask

  // rst_after > 0 aborts the frame with a reset after that many accepted pixels.
  task automatic run_frame(input int gap, input int rdy_mode, input int rst_after);
    int cnt [NB];
    int i, cyc, mn, mc, k, first, cum;
    bit done;
    for (int a = 0; a < NB; a++) cnt[a] = 0;
    mn = 1000; mc = 0;

    @(negedge clk);
    basla = 1'b1;
    for (int s = 1; s <= NB + 1; s++) begin
      @(negedge clk);
      basla = 1'b0;
      if (s == 1)      chk("mesgul_clear", 32'(mesgul), 1);
      if (s == NB)     chk("pix_rdy_in_clear", 32'(pix_rdy), 0);
      if (s == NB + 1) chk("pix_rdy_accum", 32'(pix_rdy), 1);
    end

    i = 0; cyc = 0;
    while (i < N && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      pix_vld = !(gap != 0 && (cyc % 3) == 2);
      pix = pix_vld ? PB'(frame_pix[i]) : PB'($urandom_range(0, NB - 1));
      if (pix_vld && pix_rdy) begin
        cnt[frame_pix[i]] = (cnt[frame_pix[i]] == SMAX) ? SMAX : cnt[frame_pix[i]] + 1;
        if (frame_pix[i] < mn) begin mn = frame_pix[i]; mc = 1; end
        else if (frame_pix[i] == mn && mc < SMAX) mc++;
        i++;
      end
      cyc++;
      if (rst_after > 0 && i == rst_after) break;
    end

    if (rst_after > 0) begin
      @(negedge clk);
      pix_vld = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midrst");
      rst = 1'b0;
      return;
    end
    chk("pixels_accepted", 32'(i), N);

    cum = 0;
    for (int a = 0; a < NB; a++) begin
      exp_adr_q.push_back(a);
`ifdef HISTOGRAM_CDF_EN
      cum = (cum + cnt[a] > SMAX) ? SMAX : cum + cnt[a];
      exp_dat_q.push_back(cum);
`else
      exp_dat_q.push_back(cnt[a]);
`endif
    end
    exp_cdf_min = mc;

    cyc = 0; k = 0; first = -1; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      pix_vld = 1'b1;          // must be ignored outside ACCUM
      pix = PB'(0);
      basla = (cyc == 2);      // must be ignored outside IDLE
      if (cyc == 1) chk("pix_rdy_drop", 32'(pix_rdy), 0);
      cik_rdy = (rdy_mode == 0) ? 1'b1 : ((k % 3) == 0);
      if (cik_vld) begin
        if (first < 0) begin first = cyc; chk("first_vld_lat", 32'(cyc), 3); end
        k++;
        if (exp_adr_q.size() == 0) chk("out_after_last", 32'(exp_adr_q.size()), 1);
        else begin
          chk("out_adr", 32'(cik_adr), 32'(exp_adr_q[0]));
          chk("out_dat", 32'(cik_dat), 32'(exp_dat_q[0]));
          if (cik_rdy) begin
            void'(exp_adr_q.pop_front());
            void'(exp_dat_q.pop_front());
          end
        end
      end
      if (bitti) done = 1'b1;
    end
    chk("frame_done", 32'(done), 1);
    chk("sb_left", 32'(exp_adr_q.size()), 0);
    chk("cdf_min", 32'(cdf_min), 32'(exp_cdf_min));
    chk("mesgul_end", 32'(mesgul), 0);
    @(negedge clk);
    pix_vld = 1'b0; basla = 1'b0; cik_rdy = 1'b0;
    chk("bitti_single", 32'(bitti), 0);
    chk("cdf_min_hold", 32'(cdf_min), 32'(exp_cdf_min));
    exp_adr_q.delete();
    exp_dat_q.delete();
  endtask

  initial begin
    int pat [8];
    pat = '{3, 3, 7, 3, 3, 7, 7, 3};
    rst = 1'b1; basla = 1'b0; pix_vld = 1'b0; pix = '0; cik_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // single value: bin 5 saturates at 15
    for (int i = 0; i < N; i++) frame_pix[i] = 5;
    run_frame(0, 0, 0);

    // back-to-back equal pixels exercise forwarding
    for (int i = 0; i < N; i++) frame_pix[i] = pat[i % 8];
    run_frame(0, 1, 0);

    // random frame with input gaps, then the same pixels gap-free
    for (int i = 0; i < N; i++) frame_pix[i] = $urandom_range(0, NB - 1);
    run_frame(1, 1, 0);
    run_frame(0, 0, 0);

    // reset mid-frame, then a clean frame of pixel 9
    for (int i = 0; i < N; i++) frame_pix[i] = 9;
    run_frame(0, 0, 6);
    run_frame(1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
